serial_comparator_ctrl: RTL and testbench
=========================================

# serial_comparator_ctrl

Sequencing controller that compares two WIDTH-bit unsigned operands with a single shared `comparator_4bit` slice. The slice is time-multiplexed one nibble per clock, least-significant nibble first, and its LT/EQ/GT outputs are registered back into its cascade inputs. A start/busy/done handshake fronts the controller, which sits between operand registers and any consumer needing a wide magnitude compare without instantiating WIDTH/4 comparator slices.

## Interface
- `WIDTH`, 16: operand width in bits; must be a multiple of 4 and at least 4.
- `NIBBLES`, WIDTH/4: derived local parameter; number of compare cycles.
- `clk`  input  1: single clock; all state changes on the rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `START`  input  1: request a compare of `A` and `B`.
- `A`  input  WIDTH: operand A, unsigned; sampled only on an accepted START.
- `B`  input  WIDTH: operand B, unsigned; sampled only on an accepted START.
- `BUSY`  output  1: compare in progress.
- `DONE`  output  1: one-cycle pulse; result flags are valid from this cycle on.
- `LT_OUT`, `EQ_OUT`, `GT_OUT`  output  1 each: registered result, one-hot when valid.

## Operation
- Three states:
  - IDLE: waiting for START.
  - RUN: stepping through nibbles.
  - FIN: DONE cycle.
- START is accepted in IDLE or FIN. It is ignored in RUN and is not queued.
- On accept:
  - Latch A and B into WIDTH-bit shift registers.
  - Load the cascade register to equal (LT=0, EQ=1, GT=0).
  - Clear the nibble counter.
  - Go to RUN.
- RUN, each cycle:
  - Drive the comparator with the shift registers' low nibbles and the cascade register as LT_IN/EQ_IN/GT_IN.
  - Register the comparator outputs into the cascade register.
  - Shift both operands right by 4 and increment the counter.
- RUN, on the step where counter = NIBBLES-1:
  - Copy the comparator outputs into LT_OUT/EQ_OUT/GT_OUT.
  - Go to FIN.
- FIN: DONE=1 for exactly one cycle, then IDLE, unless START is present, in which case go to RUN.
- Result flags change only at the final RUN step. They hold during the next compare and through IDLE.
- Comparator semantics: unequal nibbles decide by magnitude; equal nibbles pass the cascade inputs through. The most-significant differing nibble therefore dominates.
- Counter width is clog2(NIBBLES), minimum 1 bit. It never wraps inside a compare.
- Reset at any point, including mid-RUN:
  - State goes to IDLE.
  - BUSY=0, DONE=0, LT_OUT=EQ_OUT=GT_OUT=0 (no valid result).
  - Cascade register set to equal, counter cleared.
  - The compare in progress is discarded.
- Reset has priority over START in the same cycle.

## Timing
- Edge 0 samples START. BUSY=1 in cycles 1..NIBBLES.
- Nibble k (k = 0..NIBBLES-1) is processed between edges k and k+1. Its result is registered at edge k+1.
- Edge NIBBLES registers the final result. DONE=1 and BUSY=0 in cycle NIBBLES+1.
- START-to-DONE latency is NIBBLES cycles, which is 4 for WIDTH=16.
- Back-to-back compares: START asserted during DONE begins the next compare with no idle gap, giving a throughput of one result per NIBBLES+1 cycles.
- A and B may change freely after the accept edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package contains:
  - State encoding (IDLE, RUN, FIN).
  - Cascade constant `CMP_EQ` = 3'b010 in {LT,EQ,GT} order.
  - Reset-result constant `CMP_NONE` = 3'b000.
- One sub-module: the existing combinational `comparator_4bit`, instantiated once with port order (LT_IN, EQ_IN, GT_IN, LT_OUT, EQ_OUT, GT_OUT, A, B).
- The FSM, shift registers, counter and result register live in this module.

## Test plan
All scenarios use WIDTH=16.
- A=16'h1234, B=16'h1234, START one cycle -> BUSY high 4 cycles; DONE at cycle 5; EQ_OUT=1, LT_OUT=GT_OUT=0.
- A=16'h1235, B=16'h1234 -> GT_OUT=1. The only difference is in the lowest nibble, so the result propagates through the equal upper nibbles via cascade.
- A=16'h0FFF, B=16'h1000 -> LT_OUT=1. The top nibble dominates greater lower nibbles.
- START held high continuously with A=16'hFFFF, B=16'h0000 -> START during RUN ignored; DONE pulses every 5 cycles with GT_OUT=1; A changed mid-RUN does not alter the result.
- reset asserted in cycle 2 of a compare -> next cycle BUSY=0, DONE=0, all flags 0. A fresh START afterwards completes normally in 4 cycles.
- Back-to-back: first compare A=16'h0001, B=16'h0002 (LT); START during its DONE cycle with A=16'h8000, B=16'h7FFF -> LT_OUT holds through the second RUN; GT_OUT=1 at the second DONE, 5 cycles after the first.

Source files
------------

// File: rtl/serial_comparator_ctrl_pkg.sv
// Shared types and constants for the serial nibble-wise magnitude comparator.
// Cascade and result vectors are packed in {LT, EQ, GT} order.
package serial_comparator_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFin
  } state_e;

  localparam logic [2:0] CMP_EQ   = 3'b010;
  localparam logic [2:0] CMP_NONE = 3'b000;

endpackage

// File: rtl/comparator_4bit.sv
// Combinational 4-bit magnitude comparator slice with cascade inputs.
// Unequal nibbles decide by magnitude; equal nibbles pass the cascade through.
module comparator_4bit (
  input  logic       LT_IN,
  input  logic       EQ_IN,
  input  logic       GT_IN,
  output logic       LT_OUT,
  output logic       EQ_OUT,
  output logic       GT_OUT,
  input  logic [3:0] A,
  input  logic [3:0] B
);

  logic w_lt;
  logic w_gt;
  logic w_eq;

  assign w_lt = (A < B);
  assign w_gt = (A > B);
  assign w_eq = (A == B);

  assign LT_OUT = w_lt | (w_eq & LT_IN);
  assign EQ_OUT = w_eq & EQ_IN;
  assign GT_OUT = w_gt | (w_eq & GT_IN);

endmodule

// File: rtl/serial_comparator_ctrl.sv
// Wide unsigned magnitude compare using one shared 4-bit comparator slice,
// stepped LS nibble first with its cascade outputs fed back through a register.
module serial_comparator_ctrl
  import serial_comparator_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic             LT_OUT,
  output logic             EQ_OUT,
  output logic             GT_OUT
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned CntW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NIBBLES - 1);

  state_e            r_state;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [2:0]        r_cascade;
  logic [2:0]        r_result;
  logic [CntW-1:0]   r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [2:0]        w_cmp;

  comparator_4bit u_cmp (
    .LT_IN  (r_cascade[2]),
    .EQ_IN  (r_cascade[1]),
    .GT_IN  (r_cascade[0]),
    .LT_OUT (w_cmp[2]),
    .EQ_OUT (w_cmp[1]),
    .GT_OUT (w_cmp[0]),
    .A      (r_a[3:0]),
    .B      (r_b[3:0])
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_a       <= '0;
      r_b       <= '0;
      r_cascade <= CMP_EQ;
      r_result  <= CMP_NONE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle, StFin: begin
          if (START) begin
            r_a       <= A;
            r_b       <= B;
            r_cascade <= CMP_EQ;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= StRun;
          end else begin
            r_state <= StIdle;
          end
        end
        StRun: begin
          r_cascade <= w_cmp;
          r_a       <= r_a >> 4;
          r_b       <= r_b >> 4;
          // Counter stops at the last nibble rather than wrapping.
          if (r_cnt == LastCnt) begin
            r_result <= w_cmp;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= StFin;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign BUSY   = r_busy;
  assign DONE   = r_done;
  assign LT_OUT = r_result[2];
  assign EQ_OUT = r_result[1];
  assign GT_OUT = r_result[0];

endmodule

// File: tb/tb_serial_comparator_ctrl.sv
// Directed bench for serial_comparator_ctrl at WIDTH=16; flags checked as {LT,EQ,GT}.
module tb_serial_comparator_ctrl;

  logic        clk;
  logic        reset;
  logic        START;
  logic [15:0] A;
  logic [15:0] B;
  logic        BUSY;
  logic        DONE;
  logic        LT_OUT;
  logic        EQ_OUT;
  logic        GT_OUT;

  int n_vec;
  int n_err;

  serial_comparator_ctrl #(
    .WIDTH (16)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .START  (START),
    .A      (A),
    .B      (B),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .LT_OUT (LT_OUT),
    .EQ_OUT (EQ_OUT),
    .GT_OUT (GT_OUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] flags();
    return {LT_OUT, EQ_OUT, GT_OUT};
  endfunction

  // Caller is at a negedge; START is presented for edge 0, then cycles 1..5 are checked.
  task automatic run_cmp(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] prev, input logic [2:0] exp);
    START = 1'b1;
    A     = a;
    B     = b;
    @(negedge clk);
    START = 1'b0;
    A     = 16'hDEAD;
    B     = 16'hBEEF;
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) @(negedge clk);
      check({tag, "_busy"}, 32'(BUSY), 32'd1);
      check({tag, "_nodone"}, 32'(DONE), 32'd0);
      check({tag, "_hold"}, 32'(flags()), 32'(prev));
    end
    @(negedge clk);
    check({tag, "_done"}, 32'(DONE), 32'd1);
    check({tag, "_idle"}, 32'(BUSY), 32'd0);
    check({tag, "_flags"}, 32'(flags()), 32'(exp));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    START = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_flags", 32'(flags()), 32'd0);
    // START during reset must be ignored.
    START = 1'b1;
    @(negedge clk);
    check("rst_prio_busy", 32'(BUSY), 32'd0);
    START = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    run_cmp("eq", 16'h1234, 16'h1234, 3'b000, 3'b010);
    @(negedge clk);
    check("eq_done_pulse", 32'(DONE), 32'd0);
    check("eq_flags_idle", 32'(flags()), 32'b010);

    run_cmp("gt_lsn", 16'h1235, 16'h1234, 3'b010, 3'b001);
    @(negedge clk);
    run_cmp("lt_msn", 16'h0FFF, 16'h1000, 3'b001, 3'b100);
    @(negedge clk);

    // START held high: one DONE every 5 cycles, A disturbed mid-RUN.
    START = 1'b1;
    A     = 16'hFFFF;
    B     = 16'h0000;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 2) A = 16'h0000;
      if (c == 3) A = 16'hFFFF;
      check($sformatf("held_done_c%0d", c), 32'(DONE), ((c == 5) || (c == 10)) ? 32'd1 : 32'd0);
      check($sformatf("held_busy_c%0d", c), 32'(BUSY), ((c == 5) || (c == 10)) ? 32'd0 : 32'd1);
      if (c == 2) check("held_prev_flags", 32'(flags()), 32'b100);
      if (c >= 5) check($sformatf("held_flags_c%0d", c), 32'(flags()), 32'b001);
    end
    START = 1'b0;
    @(negedge clk);
    check("held_stop_busy", 32'(BUSY), 32'd0);
    check("held_stop_done", 32'(DONE), 32'd0);

    // Reset in cycle 2 of a compare.
    START = 1'b1;
    A     = 16'h0001;
    B     = 16'h0002;
    @(negedge clk);
    START = 1'b0;
    @(negedge clk);
    check("mid_busy_pre", 32'(BUSY), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", 32'(BUSY), 32'd0);
    check("mid_rst_done", 32'(DONE), 32'd0);
    check("mid_rst_flags", 32'(flags()), 32'd0);
    repeat (6) @(negedge clk);
    check("mid_no_done", 32'(DONE), 32'd0);
    run_cmp("post_rst", 16'hA5A5, 16'hA5A5, 3'b000, 3'b010);
    @(negedge clk);

    // Back-to-back: restart in the DONE cycle of the first compare.
    run_cmp("b2b_first", 16'h0001, 16'h0002, 3'b010, 3'b100);
    run_cmp("b2b_second", 16'h8000, 16'h7FFF, 3'b100, 3'b001);
    @(negedge clk);
    check("b2b_end_done", 32'(DONE), 32'd0);
    check("b2b_end_flags", 32'(flags()), 32'b001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
